// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a registered one-hot grant.
// A grant is held until done, the owner drops its request, or HOLD_MAX cycles elapse.
module rr_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] owner;
  logic [7:0] cnt;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       hold_hit;
  logic       release_grant;

  // Rotating priority search starting at ptr, wrapping 3 -> 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    hold_hit      = (HOLD_MAX != 0) && (cnt == HOLD_LAST);
    release_grant = done || !req[owner] || hold_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= 4'b0001 << winner;
            owner <= winner;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (release_grant) begin
            gnt     <= '0;
            busy    <= 1'b0;
            ptr     <= owner + 2'd1;
            state   <= IDLE;
            // Flag only a release forced purely by the hold limit.
            timeout <= hold_hit && !done && req[owner];
          end else if (cnt != '1) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter with registered, one-hot grant output.
- Sits directly upstream of the 4-to-2 encoder: gnt[3:0] drives the encoder's d[3:0], so the encoder always sees one-hot or all-zero input.
- Holds the grant until the owner finishes, drops its request, or hits a hold-time limit.
- Rotates priority after every release.

Parameters:
- HOLD_MAX, 8, maximum grant length in cycles (1..255). 0 disables the timeout.

Ports:
- clk      input   1  rising-edge clock
- rst_n    input   1  synchronous active-low reset
- req      input   4  request lines, one per requester, level-sensitive
- done     input   1  current owner finished; releases grant
- gnt      output  4  registered one-hot grant; 4'b0000 when idle
- busy     output  1  1 while a grant is held (equals |gnt)
- timeout  output  1  single-cycle pulse when a grant is forcibly released by HOLD_MAX

Behaviour:
- Reset, sampled on a clk edge with rst_n=0:
  - state=IDLE, gnt=0, busy=0, timeout=0, ptr=0, cnt=0.
  - Reset mid-grant drops gnt on that same edge.
  - req is ignored while rst_n=0.
- Internal state:
  - ptr (2 bit): index with highest priority.
  - owner (2 bit): index currently granted.
  - cnt (8 bit): grant-length counter.
  - FSM states: IDLE, GRANT.
- IDLE:
  - If req != 0, search from ptr upward, wrapping 3->0; the first set bit wins.
  - Next edge: gnt = one-hot(winner), owner = winner, cnt = 0, busy = 1, state = GRANT.
  - Latency is 1 cycle from req sampled to gnt asserted.
  - If req == 0, remain in IDLE with gnt = 0.
- GRANT: gnt is held constant. The release condition, evaluated each edge, is any of:
  - done=1
  - req[owner]=0
  - HOLD_MAX != 0 and cnt == HOLD_MAX-1
- GRANT, when the release condition is true, on the next edge:
  - gnt = 0, busy = 0, ptr = owner+1 (mod 4), state = IDLE.
  - timeout = 1 only when the timeout was the sole cause; done or a dropped request take precedence.
- GRANT, when the release condition is false: cnt increments, saturating at 255.
- Mandatory idle bubble: after every release there is at least one cycle with gnt=0 before the next grant. Downstream sees no back-to-back grant change without a gap.
- Two grants never overlap.
- timeout auto-clears after one cycle.
- Requests other than the owner's that arrive or change during GRANT are ignored until IDLE. Only the owner's own request line is tracked.
- done asserted during IDLE has no effect.
- Simultaneous requests are resolved purely by ptr rotation. No requester is granted twice while another requester continuously holds req.
- gnt is a pure flop output with no combinational path from req or done.

Test Plan:
1. Reset, then req=4'b0000 for 5 cycles -> gnt=0, busy=0, timeout=0 throughout.
2. Single requester:
   - req=4'b0100 held, done pulsed on the 3rd grant cycle -> gnt=4'b0100 one cycle after req.
   - Release on the edge after done, then gnt=0 for one cycle, then gnt=4'b0100 re-granted.
   - ptr is now 3.
3. Round-robin: req=4'b1111 held, done pulsed every grant cycle -> grant order 0001,0010,0100,1000,0001 with a 0000 bubble between each.
4. Timeout: HOLD_MAX=4, req=4'b0010 held, done=0 -> gnt=4'b0010 for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle, then re-grant.
5. Owner drops request: grant to 4'b1000, then req[3] falls -> gnt=0 next edge, timeout=0, ptr=0.
6. Reset mid-grant: gnt=4'b0010, rst_n=0 for one edge -> gnt=0, ptr=0. With req=4'b1010 after reset, the next grant is 4'b0010.
